// File: rtl/reg_seq_pkg.sv
// Shared types and decode for the register-file access sequencer.
// Instruction layout: [9:6] op, [5:4] rd, [3:2] rs0, [1:0] rs1.
package reg_seq_pkg;

    localparam int REG_DATA_W = 10;
    localparam int REG_ADDR_W = 2;
    localparam int INSTR_W    = 10;

    localparam int OP_MSB  = 9;
    localparam int OP_LSB  = 6;
    localparam int RD_MSB  = 5;
    localparam int RD_LSB  = 4;
    localparam int RS0_MSB = 3;
    localparam int RS0_LSB = 2;
    localparam int RS1_MSB = 1;
    localparam int RS1_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_MOV = 4'd6,
        OP_LDI = 4'd7
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WRITE
    } state_t;

    typedef struct packed {
        logic rd0;
        logic rd1;
        logic wr;
        logic upd_c;
        logic upd_z;
        logic illegal;
    } op_ctrl_t;

    // Opcodes 8-15 are illegal and behave as NOP apart from the error flag.
    function automatic op_ctrl_t decode_op(input logic [3:0] op);
        op_ctrl_t c;
        c = '0;
        case (op)
            OP_NOP: c = '0;
            OP_ADD, OP_SUB: begin
                c.rd0 = 1'b1; c.rd1 = 1'b1; c.wr = 1'b1;
                c.upd_c = 1'b1; c.upd_z = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR: begin
                c.rd0 = 1'b1; c.rd1 = 1'b1; c.wr = 1'b1; c.upd_z = 1'b1;
            end
            OP_MOV: begin
                c.rd0 = 1'b1; c.wr = 1'b1;
            end
            OP_LDI: c.wr = 1'b1;
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU for the sequencer; all arithmetic is unsigned modulo 2^DATA_W.
module seq_alu
    import reg_seq_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero_valid,
    output logic              carry_valid
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    // The extra top bit of the difference is the borrow (set iff a < b).
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result      = '0;
        carry       = 1'b0;
        zero_valid  = 1'b0;
        carry_valid = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[DATA_W-1:0]; carry = sum[DATA_W];
                zero_valid = 1'b1; carry_valid = 1'b1;
            end
            OP_SUB: begin
                result = diff[DATA_W-1:0]; carry = diff[DATA_W];
                zero_valid = 1'b1; carry_valid = 1'b1;
            end
            OP_AND: begin result = a & b; zero_valid = 1'b1; end
            OP_OR:  begin result = a | b; zero_valid = 1'b1; end
            OP_XOR: begin result = a ^ b; zero_valid = 1'b1; end
            OP_MOV: result = a;
            OP_LDI: result = imm;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/reg_access_sequencer.sv
// Initiator for a 4-entry register file: READ -> EXEC -> WRITE per instruction,
// one instruction in flight, all state on the falling edge of CLKb.
module reg_access_sequencer
    import reg_seq_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic               CLKb,
    input  logic               RSTb,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [INSTR_W-1:0] IN_INSTR,
    input  logic [DATA_W-1:0]  IN_IMM,
    output logic               ENR0,
    output logic               ENR1,
    output logic [ADDR_W-1:0]  RDA0,
    output logic [ADDR_W-1:0]  RDA1,
    input  logic [DATA_W-1:0]  Q0,
    input  logic [DATA_W-1:0]  Q1,
    output logic               ENW,
    output logic [ADDR_W-1:0]  WRA,
    output logic [DATA_W-1:0]  D,
    output logic               DONE,
    output logic [DATA_W-1:0]  RESULT,
    output logic               C,
    output logic               Z,
    output logic               ERR
);

    state_t             state_reg;
    logic [INSTR_W-1:0] instr_reg;
    logic [DATA_W-1:0]  imm_reg;
    logic [DATA_W-1:0]  result_reg;
    logic               c_reg;
    logic               z_reg;

    logic [3:0]         op;
    op_ctrl_t           ctrl;
    logic [DATA_W-1:0]  alu_result;
    logic               alu_carry;
    logic               alu_zero_valid;
    logic               alu_carry_valid;

    assign op   = instr_reg[OP_MSB:OP_LSB];
    assign ctrl = decode_op(op);

    seq_alu #(.DATA_W(DATA_W)) u_alu (
        .op          (op),
        .a           (Q0),
        .b           (Q1),
        .imm         (imm_reg),
        .result      (alu_result),
        .carry       (alu_carry),
        .zero_valid  (alu_zero_valid),
        .carry_valid (alu_carry_valid)
    );

    always_ff @(negedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            state_reg  <= ST_IDLE;
            instr_reg  <= '0;
            imm_reg    <= '0;
            result_reg <= '0;
            c_reg      <= 1'b0;
            z_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        instr_reg <= IN_INSTR;
                        imm_reg   <= IN_IMM;
                        state_reg <= ST_READ;
                    end
                end
                ST_READ: state_reg <= ST_EXEC;
                ST_EXEC: begin
                    // NOP and illegal ops leave RESULT and the flags untouched.
                    if (ctrl.wr)
                        result_reg <= alu_result;
                    if (ctrl.upd_c && alu_carry_valid)
                        c_reg <= alu_carry;
                    if (ctrl.upd_z && alu_zero_valid)
                        z_reg <= (alu_result == '0);
                    state_reg <= ST_WRITE;
                end
                ST_WRITE: state_reg <= ST_IDLE;
                default:  state_reg <= ST_IDLE;
            endcase
        end
    end

    // Port strobes are pure decodes of the state flops, so reset clears them at once.
    always_comb begin
        IN_READY = (state_reg == ST_IDLE);
        ENR0     = (state_reg == ST_READ) && ctrl.rd0;
        ENR1     = (state_reg == ST_READ) && ctrl.rd1;
        RDA0     = (state_reg == ST_READ) ? instr_reg[RS0_MSB:RS0_LSB] : '0;
        RDA1     = (state_reg == ST_READ) ? instr_reg[RS1_MSB:RS1_LSB] : '0;
        ENW      = (state_reg == ST_WRITE) && ctrl.wr;
        WRA      = ENW ? instr_reg[RD_MSB:RD_LSB] : '0;
        D        = ENW ? result_reg : '0;
        DONE     = (state_reg == ST_WRITE);
        ERR      = (state_reg == ST_WRITE) && ctrl.illegal;
        RESULT   = result_reg;
        C        = c_reg;
        Z        = z_reg;
    end

endmodule

// File: tb/tb_reg_access_sequencer.sv
// Self-checking bench: behavioural register file on the pins, an instruction-level
// model checked every rising edge, and directed instructions with literal expectations.
module tb_reg_access_sequencer;

    logic       CLKb = 1'b1;
    logic       RSTb = 1'b0;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [9:0] IN_INSTR = '0;
    logic [9:0] IN_IMM = '0;
    logic       ENR0, ENR1, ENW, DONE, C, Z, ERR;
    logic [1:0] RDA0, RDA1, WRA;
    logic [9:0] Q0 = '0;
    logic [9:0] Q1 = '0;
    logic [9:0] D, RESULT;

    int checks = 0;
    int passes = 0;
    int done_cnt = 0;
    int enw_rises = 0;

    always #5 CLKb = ~CLKb;

    reg_access_sequencer dut (
        .CLKb(CLKb), .RSTb(RSTb), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_INSTR(IN_INSTR), .IN_IMM(IN_IMM), .ENR0(ENR0), .ENR1(ENR1),
        .RDA0(RDA0), .RDA1(RDA1), .Q0(Q0), .Q1(Q1), .ENW(ENW), .WRA(WRA),
        .D(D), .DONE(DONE), .RESULT(RESULT), .C(C), .Z(Z), .ERR(ERR)
    );

    // Register file on the far side of the interface (never reset).
    logic [9:0] rf [4] = '{default: 10'h000};
    always @(negedge CLKb) begin
        if (ENW)  rf[WRA] <= D;
        if (ENR0) Q0 <= rf[RDA0];
        if (ENR1) Q1 <= rf[RDA1];
    end

    always @(posedge CLKb) if (DONE) done_cnt++;
    always @(posedge ENW) enw_rises++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Instruction-level model: phase counts edges since acceptance, architectural
    // registers and flags follow the opcode rules directly.
    int         ph = 0;
    logic [9:0] m_instr = '0;
    logic [9:0] m_imm = '0;
    logic [9:0] m_res = '0;
    logic       m_c = 1'b0;
    logic       m_z = 1'b0;
    logic [9:0] mregs [4] = '{default: 10'h000};

    always @(negedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            ph = 0; m_instr = '0; m_imm = '0; m_res = '0; m_c = 1'b0; m_z = 1'b0;
        end else begin
            int op, a, b, r;
            op = int'(m_instr[9:6]);
            case (ph)
                0: if (IN_VALID) begin m_instr = IN_INSTR; m_imm = IN_IMM; ph = 1; end
                1: ph = 2;
                2: begin
                    a = int'(mregs[m_instr[3:2]]);
                    b = int'(mregs[m_instr[1:0]]);
                    r = 0;
                    case (op)
                        1: begin r = (a + b) % 1024; m_c = (a + b) > 1023; end
                        2: begin r = (a - b + 1024) % 1024; m_c = a < b; end
                        3: r = a & b;
                        4: r = a | b;
                        5: r = a ^ b;
                        6: r = a;
                        7: r = int'(m_imm);
                        default: r = 0;
                    endcase
                    if (op >= 1 && op <= 5) m_z = (r == 0);
                    if (op >= 1 && op <= 7) m_res = r[9:0];
                    ph = 3;
                end
                default: begin
                    if (op >= 1 && op <= 7) mregs[m_instr[5:4]] = m_res;
                    ph = 0;
                end
            endcase
        end
    end

    // Per-cycle compare; fields the behaviour leaves open are masked out.
    always @(posedge CLKb) begin
        int op;
        logic rd0, rd1, wr;
        logic [33:0] act, exp, msk;
        op  = int'(m_instr[9:6]);
        rd0 = op >= 1 && op <= 6;
        rd1 = op >= 1 && op <= 5;
        wr  = op >= 1 && op <= 7;
        act = {IN_READY, ENR0, ENR1, RDA0, RDA1, ENW, WRA, D, DONE, RESULT, C, Z, ERR};
        exp = {ph == 0, ph == 1 && rd0, ph == 1 && rd1,
               (ph == 1) ? m_instr[3:2] : 2'b00, (ph == 1) ? m_instr[1:0] : 2'b00,
               ph == 3 && wr, (ph == 3 && wr) ? m_instr[5:4] : 2'b00,
               (ph == 3 && wr) ? m_res : 10'h000,
               ph == 3, m_res, m_c, m_z, ph == 3 && op >= 8};
        msk = '1;
        if (ph == 1 && !rd0) msk[30:29] = 2'b00;
        if (ph == 1 && !rd1) msk[28:27] = 2'b00;
        if (ph == 3 && !wr)  msk[25:14] = '0;
        checks++;
        if (((act ^ exp) & msk) == '0) passes++;
        else $display("FAIL cycle_model: got %09h expected %09h mask %09h", act, exp, msk);
    end

    task automatic wait_ready();
        int n = 0;
        @(posedge CLKb);
        while (!IN_READY && n < 10) begin @(posedge CLKb); n++; end
        if (!IN_READY) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs0,
                          input logic [1:0] rs1, input logic [9:0] imm, input logic [1:0] exp_enr,
                          input logic exp_enw, input logic [9:0] exp_d, input logic exp_c,
                          input logic exp_z, input logic exp_err, input logic [9:0] exp_result);
        wait_ready();
        IN_INSTR = {op, rd, rs0, rs1};
        IN_IMM   = imm;
        IN_VALID = 1'b1;
        @(posedge CLKb);
        IN_VALID = 1'b0;
        chk("read_ready", IN_READY, 0);
        chk("read_enr", {ENR0, ENR1}, exp_enr);
        if (exp_enr[1]) chk("read_rda0", RDA0, rs0);
        if (exp_enr[0]) chk("read_rda1", RDA1, rs1);
        @(posedge CLKb);
        chk("exec_ready", IN_READY, 0);
        chk("exec_enr", {ENR0, ENR1}, 0);
        @(posedge CLKb);
        chk("write_ready", IN_READY, 0);
        chk("write_done", DONE, 1);
        chk("write_enw", ENW, exp_enw);
        if (exp_enw) begin
            chk("write_wra", WRA, rd);
            chk("write_d", D, exp_d);
        end
        chk("write_err", ERR, exp_err);
        chk("write_c", C, exp_c);
        chk("write_z", Z, exp_z);
        chk("write_result", RESULT, exp_result);
        @(posedge CLKb);
        chk("idle_ready", IN_READY, 1);
        $display("op=%0h rd=%0d rs0=%0d rs1=%0d imm=%03h -> D=%03h RESULT=%03h C=%0d Z=%0d ERR=%0d",
                 op, rd, rs0, rs1, imm, D, RESULT, C, Z, ERR);
    endtask

    initial begin
        int d0;
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int d0, e0;
        repeat (2) @(posedge CLKb);
        chk("reset_ready", IN_READY, 1);
        chk("reset_outputs", {ENR0, ENR1, ENW, DONE, ERR, C, Z, RESULT}, 0);
        #2 RSTb = 1'b1;

        // LDI to every register
        run_op(4'h7, 2'd0, 2'd0, 2'd0, 10'h001, 2'b00, 1, 10'h001, 0, 0, 0, 10'h001);
        run_op(4'h7, 2'd1, 2'd0, 2'd0, 10'h3FF, 2'b00, 1, 10'h3FF, 0, 0, 0, 10'h3FF);
        run_op(4'h7, 2'd2, 2'd0, 2'd0, 10'h155, 2'b00, 1, 10'h155, 0, 0, 0, 10'h155);
        run_op(4'h7, 2'd3, 2'd0, 2'd0, 10'h000, 2'b00, 1, 10'h000, 0, 0, 0, 10'h000);

        // ADD overflow: 0x3FF + 0x001
        run_op(4'h7, 2'd2, 2'd0, 2'd0, 10'h001, 2'b00, 1, 10'h001, 0, 0, 0, 10'h001);
        run_op(4'h1, 2'd3, 2'd1, 2'd2, 10'h000, 2'b11, 1, 10'h000, 1, 1, 0, 10'h000);

        // SUB borrow: 5 - 7, then AND keeps C
        run_op(4'h7, 2'd0, 2'd0, 2'd0, 10'h005, 2'b00, 1, 10'h005, 1, 1, 0, 10'h005);
        run_op(4'h7, 2'd1, 2'd0, 2'd0, 10'h007, 2'b00, 1, 10'h007, 1, 1, 0, 10'h007);
        run_op(4'h2, 2'd2, 2'd0, 2'd1, 10'h000, 2'b11, 1, 10'h3FE, 1, 0, 0, 10'h3FE);
        run_op(4'h3, 2'd3, 2'd2, 2'd1, 10'h000, 2'b11, 1, 10'h006, 1, 0, 0, 10'h006);

        // Illegal opcode then NOP: no traffic, state untouched
        run_op(4'hA, 2'd1, 2'd2, 2'd3, 10'h3FF, 2'b00, 0, 10'h000, 1, 0, 1, 10'h006);
        run_op(4'h0, 2'd1, 2'd2, 2'd3, 10'h3FF, 2'b00, 0, 10'h000, 1, 0, 0, 10'h006);

        // Dependent ADD r0=r0+r0 twice with IN_VALID held
        run_op(4'h7, 2'd0, 2'd0, 2'd0, 10'h100, 2'b00, 1, 10'h100, 1, 0, 0, 10'h100);
        wait_ready();
        d0 = done_cnt;
        IN_INSTR = {4'h1, 2'd0, 2'd0, 2'd0};
        IN_VALID = 1'b1;
        repeat (3) @(posedge CLKb);
        chk("dep1_d", D, 10'h200);
        chk("dep1_c", C, 0);
        @(posedge CLKb);
        chk("dep_idle_ready", IN_READY, 1);
        @(posedge CLKb);
        IN_VALID = 1'b0;
        repeat (2) @(posedge CLKb);
        chk("dep2_d", D, 10'h000);
        chk("dep2_cz", {C, Z}, 2'b11);
        repeat (6) @(posedge CLKb);
        chk("dep_done_count", done_cnt - d0, 2);
        chk("dep_rf0", rf[0], 10'h000);
        $display("dependent pair: done pulses=%0d rf0=%03h", done_cnt - d0, rf[0]);

        // Reset during EXEC of ADD r3=r0+r1
        run_op(4'h7, 2'd3, 2'd0, 2'd0, 10'h2AA, 2'b00, 1, 10'h2AA, 1, 1, 0, 10'h2AA);
        wait_ready();
        e0 = enw_rises;
        IN_INSTR = {4'h1, 2'd3, 2'd0, 2'd1};
        IN_VALID = 1'b1;
        @(posedge CLKb);
        IN_VALID = 1'b0;
        @(posedge CLKb);
        #2 RSTb = 1'b0;
        #1;
        chk("rst_immediate", {IN_READY, ENR0, ENR1, ENW, DONE, ERR}, 6'b100000);
        chk("rst_flags", {RESULT, C, Z}, 0);
        @(posedge CLKb);
        #2 RSTb = 1'b1;
        repeat (4) @(posedge CLKb);
        chk("rst_no_write", enw_rises - e0, 0);
        chk("rst_rf3", rf[3], 10'h2AA);
        chk("rst_ready", IN_READY, 1);
        $display("reset abort: enw rises=%0d rf3=%03h", enw_rises - e0, rf[3]);

        run_op(4'h7, 2'd1, 2'd0, 2'd0, 10'h0F0, 2'b00, 1, 10'h0F0, 0, 0, 0, 10'h0F0);
        run_op(4'h6, 2'd2, 2'd3, 2'd0, 10'h000, 2'b10, 1, 10'h2AA, 0, 0, 0, 10'h2AA);

        repeat (2) @(posedge CLKb);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
